uart_boot_loader: RTL and testbench

//  - Upstream of the CPU core: receives a program image over UART and writes it word-by-word into instruction/data memory.
//  - Holds the CPU in reset (cpu_hold) until a complete, valid image has been loaded.
//  - Releases the CPU at pc=0 only after the image is fully written and, when enabled, the checksum matches.

---
 rtl/uart_boot_loader_pkg.sv | 29 ++
 rtl/uart_rx_byte.sv | 91 +++++++++
 rtl/uart_boot_loader.sv | 156 +++++++++++++++
 tb/tb_uart_boot_loader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_boot_loader_pkg.sv
// Shared constants and state encodings for the UART boot loader.
// The optional checksum stage is controlled by the BOOT_CHECKSUM_EN macro.
package uart_boot_loader_pkg;

  localparam logic [7:0] BOOT_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } boot_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // States in which a stalled sender is treated as an aborted frame.
  function automatic logic timeout_active(input boot_state_t s);
    return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchroniser, mid-bit sampling, start-bit
// glitch rejection and stop-bit framing check.
module uart_rx_byte
  import uart_boot_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t        state;
  rx_state_t        state_next;
  logic             rx_meta;
  logic             rx_s;
  logic             rx_prev;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             fall;
  logic             half_tick;
  logic             bit_tick;

  assign fall      = rx_prev & ~rx_s;
  assign half_tick = (cnt == HALF_LAST);
  assign bit_tick  = (cnt == BIT_LAST);
  assign byte_data = shreg;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RX_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RX_IDLE:  if (fall) state_next = RX_START;
      RX_START: if (half_tick) state_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_tick && bit_idx == 3'd7) state_next = RX_STOP;
      RX_STOP:  if (bit_tick) state_next = RX_IDLE;
      default:  state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      // The half-bit realignment in START puts every later tick mid-bit.
      if (state == RX_IDLE || (state == RX_START && half_tick) || bit_tick) cnt <= '0;
      else cnt <= cnt + 1'b1;
      if (state == RX_IDLE) bit_idx <= '0;
      if (state == RX_DATA && bit_tick) begin
        shreg   <= {rx_s, shreg[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
      if (state == RX_STOP && bit_tick) begin
        byte_valid <= rx_s;
        frame_err  <= ~rx_s;
      end
    end
  end

endmodule

// File: rtl/uart_boot_loader.sv
// Receives a framed program image over UART, writes it word by word into memory
// and releases the CPU when complete. BOOT_CHECKSUM_EN adds a trailing XOR check.
module uart_boot_loader
  import uart_boot_loader_pkg::*;
#(
  parameter int CLK_HZ         = 100_000_000,
  parameter int BAUD           = 115200,
  parameter int MAX_WORDS      = 4096,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        CLK100MHZ,
  input  logic        rst,
  input  logic        uart_rx,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        boot_done,
  output logic        boot_err
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int IDX_W        = $clog2(MAX_WORDS) + 1;
  localparam int TMO_W        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0]      MAX_LEN  = 17'(MAX_WORDS);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES);

  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             frame_err;
  boot_state_t      state;
  boot_state_t      state_next;
  logic [15:0]      len;
  logic [IDX_W-1:0] word_idx;
  logic [1:0]       byte_idx;
  logic [23:0]      word_buf;
  logic [TMO_W-1:0] tmo_cnt;
  logic             active;
  logic             tmo_hit;
  logic             is_sync;
  logic [16:0]      len_new;
  logic             len_ok;
  logic             last_word;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (CLK100MHZ),
    .rst       (rst),
    .rx        (uart_rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  assign active    = timeout_active(state);
  assign tmo_hit   = active && (tmo_cnt == TMO_LAST);
  assign is_sync   = byte_valid && (byte_data == BOOT_SYNC_BYTE);
  assign len_new   = {1'b0, byte_data, len[7:0]};
  assign len_ok    = (len_new != 17'd0) && (len_new <= MAX_LEN);
  assign last_word = (32'(word_idx) == 32'(len));

  assign cpu_hold  = (state != ST_DONE);
  assign boot_done = (state == ST_DONE);
  assign boot_err  = (state == ST_ERROR);

  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (is_sync) state_next = ST_LEN0;
      ST_LEN0:  if (byte_valid) state_next = ST_LEN1;
      ST_LEN1:  if (byte_valid) state_next = len_ok ? ST_DATA : ST_ERROR;
      // word_idx is already advanced while mem_we is high.
      ST_DATA: begin
        if (mem_we && last_word) begin
`ifdef BOOT_CHECKSUM_EN
          state_next = ST_CSUM;
`else
          state_next = ST_DONE;
`endif
        end
      end
`ifdef BOOT_CHECKSUM_EN
      ST_CSUM:  if (byte_valid) state_next = (byte_data == csum) ? ST_DONE : ST_ERROR;
`endif
      ST_DONE:  state_next = ST_DONE;
      ST_ERROR: if (is_sync) state_next = ST_LEN0;
      default:  state_next = ST_IDLE;
    endcase
    if (frame_err && state != ST_IDLE && state != ST_DONE) state_next = ST_ERROR;
    // A byte landing on the timeout cycle still counts as progress.
    if (tmo_hit && !byte_valid) state_next = ST_ERROR;
  end

  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) tmo_cnt <= '0;
    else if (!active || byte_valid) tmo_cnt <= '0;
    else if (tmo_cnt != TMO_LAST) tmo_cnt <= tmo_cnt + 1'b1;
  end

  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      len       <= '0;
      word_idx  <= '0;
      byte_idx  <= '0;
      word_buf  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      if (byte_valid) begin
        case (state)
          ST_LEN0: len[7:0] <= byte_data;
          ST_LEN1: begin
            len[15:8] <= byte_data;
            word_idx  <= '0;
            byte_idx  <= '0;
          end
          ST_DATA: begin
            byte_idx <= byte_idx + 1'b1;
            if (byte_idx == 2'd3) begin
              mem_we    <= 1'b1;
              mem_addr  <= 32'(word_idx) << 2;
              mem_wdata <= {byte_data, word_buf};
              word_idx  <= word_idx + 1'b1;
            end else begin
              word_buf[{byte_idx, 3'b000} +: 8] <= byte_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef BOOT_CHECKSUM_EN
  // Running XOR over LEN and data bytes; the sync byte is not included.
  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) csum <= '0;
    else if (byte_valid) begin
      if (state == ST_LEN0) csum <= byte_data;
      else if (state == ST_LEN1 || state == ST_DATA) csum <= csum ^ byte_data;
    end
  end
`endif

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader; adapts its final image test to BOOT_CHECKSUM_EN.
module tb_uart_boot_loader;

  localparam int CPB = 16;
  localparam int TMO = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        uart_rx;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        boot_done;
  logic        boot_err;

  int n_checks = 0;
  int n_errors = 0;
  int write_cnt = 0;
  int cyc = 0;
  int last_we_cyc = 0;
  int done_cyc = 0;
  bit done_seen = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  tx_q[$];

  uart_boot_loader #(
    .CLK_HZ        (CPB * 115200),
    .BAUD          (115200),
    .MAX_WORDS     (16),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK100MHZ(clk),
    .rst      (rst),
    .uart_rx  (uart_rx),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_hold (cpu_hold),
    .boot_done(boot_done),
    .boot_err (boot_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every write strobe is matched against the expected queue.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst && mem_we) begin
      write_cnt++;
      last_we_cyc = cyc;
      if (exp_q.size() != 0) check("write", {mem_addr, mem_wdata}, exp_q.pop_front());
    end
    if (!rst && boot_done && !done_seen) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    write_cnt = 0;
    done_seen = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    logic [9:0] frame;
    frame = {~bad_stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = frame[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_queue();
    while (tx_q.size() != 0) send_byte(tx_q.pop_front(), 1'b0);
  endtask

  task automatic send_glitch();
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    uart_rx = 1'b1;
    #1;
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_boot_done", boot_done, 0);
    check("rst_boot_err", boot_err, 0);
    do_reset();

    // Garbage before sync is ignored.
    tx_q = '{8'h00, 8'hFF, 8'h12};
    send_queue();
    check("garbage_err", boot_err, 0);
    check("garbage_hold", cpu_hold, 1);
    check("garbage_writes", write_cnt, 0);

    // Length bounds, and sync clearing the error.
    tx_q = '{8'hA5, 8'h00, 8'h00};
    send_queue();
    check("len0_err", boot_err, 1);
    send_byte(8'hA5, 1'b0);
    check("sync_clears_err", boot_err, 0);
    tx_q = '{8'h11, 8'h00};
    send_queue();
    check("len_max_plus1_err", boot_err, 1);
    tx_q = '{8'hA5, 8'h00, 8'h01};
    send_queue();
    check("len_hi_err", boot_err, 1);
    tx_q = '{8'hA5, 8'h10, 8'h00};
    send_queue();
    check("len_max_ok", boot_err, 0);
    // Stall: still fine short of the limit, aborted after it.
    repeat (TMO - 100) @(negedge clk);
    check("pre_timeout_err", boot_err, 0);
    repeat (200) @(negedge clk);
    check("timeout_err", boot_err, 1);
    check("len_writes", write_cnt, 0);

    // Bad stop bit on the second data byte.
    do_reset();
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'h11};
    send_queue();
    send_byte(8'h22, 1'b1);
    tx_q = '{8'h33, 8'h44};
    send_queue();
    check("frame_err", boot_err, 1);
    check("frame_hold", cpu_hold, 1);
    check("frame_writes", write_cnt, 0);

    // Start glitch inside a frame, then reset mid-way through the second word.
    do_reset();
    exp_q.push_back({32'h0, 32'h44332211});
    tx_q = '{8'hA5, 8'h02, 8'h00};
    send_queue();
    send_glitch();
    tx_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_queue();
    check("glitch_writes", write_cnt, 1);
    check("glitch_wdata_held", mem_wdata, 32'h44332211);
    #2 rst = 1'b1;
    #1;
    check("midrst_mem_we", mem_we, 0);
    check("midrst_mem_addr", mem_addr, 0);
    check("midrst_mem_wdata", mem_wdata, 0);
    check("midrst_cpu_hold", cpu_hold, 1);
    check("midrst_boot_done", boot_done, 0);
    check("midrst_boot_err", boot_err, 0);
    check("midrst_writes", write_cnt, 1);
    do_reset();

`ifdef BOOT_CHECKSUM_EN
    // Wrong checksum: writes still happen, CPU stays held.
    exp_q.push_back({32'h0, 32'h00000013});
    exp_q.push_back({32'h4, 32'h0000006F});
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h00};
    send_queue();
    check("badcsum_writes", write_cnt, 2);
    check("badcsum_err", boot_err, 1);
    check("badcsum_hold", cpu_hold, 1);
    check("badcsum_done", boot_done, 0);
    write_cnt = 0;
    exp_q.push_back({32'h0, 32'h00000013});
    exp_q.push_back({32'h4, 32'h0000006F});
    send_byte(8'hA5, 1'b0);
    check("resync_err", boot_err, 0);
    tx_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7E};
    send_queue();
    check("csum_writes", write_cnt, 2);
    check("csum_done", boot_done, 1);
    check("csum_hold", cpu_hold, 0);
    check("csum_err", boot_err, 0);
    check("exp_q_empty", exp_q.size(), 0);
`else
    exp_q.push_back({32'h0, 32'h00000013});
    exp_q.push_back({32'h4, 32'h0000006F});
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    send_queue();
    check("img2_writes", write_cnt, 2);
    check("img2_done", boot_done, 1);
    check("img2_hold", cpu_hold, 0);
    check("img2_done_latency", done_cyc - last_we_cyc, 1);
    do_reset();
    exp_q.push_back({32'h0, 32'h12345678});
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    send_queue();
    check("img1_writes", write_cnt, 1);
    check("img1_done", boot_done, 1);
    check("img1_done_latency", done_cyc - last_we_cyc, 1);
    check("exp_q_empty", exp_q.size(), 0);
`endif

    // Traffic after DONE is ignored.
    write_cnt = 0;
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    send_queue();
    check("post_done_writes", write_cnt, 0);
    check("post_done_sticky", boot_done, 1);
    check("post_done_hold", cpu_hold, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
